// File: rtl/pixel_fetch_fifo_if.sv
// Bus bundle for pixel_fetch_fifo: write beats from the memory controller,
// word reads from the VGA side, and the occupancy/status outputs.
interface pixel_fetch_fifo_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 64
);
  logic                      wr_en;
  logic [LANES*DATA_W-1:0]   data_in;
  logic                      rd_en;
  logic                      flush;
  logic [DATA_W-1:0]         data_out;
  logic                      rd_valid;
  logic [$clog2(DEPTH):0]    nwords;
  logic                      full;
  logic                      empty;
  logic                      low;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output wr_en, data_in, rd_en, flush,
    input  data_out, rd_valid, nwords, full, empty, low, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, flush,
    output data_out, rd_valid, nwords, full, empty, low, overflow, underflow
  );
endinterface

// File: rtl/pixel_fetch_fifo.sv
// Pixel line FIFO: LANES words written per beat, one word read per cycle,
// registered read data, low-water refill request and sticky error flags.
module pixel_fetch_fifo #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LANES    = 2,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LOW_MARK = 16
) (
  input logic              clk,
  input logic              rst,
  pixel_fetch_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [NW-1:0] FullAbove = NW'(DEPTH - LANES);
  localparam logic [NW-1:0] LowMark   = NW'(LOW_MARK);
  localparam logic [NW-1:0] BeatWords = NW'(LANES);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]     nwords_q, nwords_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty, wr_accept, rd_accept;

  assign full  = nwords_q > FullAbove;
  assign empty = nwords_q == '0;

  // Acceptance uses pre-edge occupancy only; flush blocks both sides.
  assign wr_accept = bus.wr_en & ~full  & ~bus.flush;
  assign rd_accept = bus.rd_en & ~empty & ~bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    nwords_d    = nwords_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      nwords_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + AW'(LANES);
      end
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      rd_valid_d  = rd_accept;
      overflow_d  = overflow_q | (bus.wr_en & full);
      underflow_d = underflow_q | (bus.rd_en & empty);

      case ({wr_accept, rd_accept})
        2'b10:   nwords_d = nwords_q + BeatWords;
        2'b01:   nwords_d = nwords_q - NW'(1);
        2'b11:   nwords_d = nwords_q + BeatWords - NW'(1);
        default: nwords_d = nwords_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      nwords_q    <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      nwords_q    <= nwords_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; a beat landing during reset is simply not written.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        mem_q[wr_ptr_q + AW'(l)] <= bus.data_in[l*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.nwords    = nwords_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.low       = nwords_q < LowMark;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pixel_fetch_fifo.sv
// Scoreboard bench for pixel_fetch_fifo: default 16x2x64 instance plus an
// 8x4x32 instance for the alternate geometry.
module tb_pixel_fetch_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_fetch_fifo_if #(.DATA_W(16), .LANES(2), .DEPTH(64)) bus_a ();
  pixel_fetch_fifo_if #(.DATA_W(8),  .LANES(4), .DEPTH(32)) bus_b ();

  pixel_fetch_fifo #(.DATA_W(16), .LANES(2), .DEPTH(64), .LOW_MARK(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pixel_fetch_fifo #(.DATA_W(8), .LANES(4), .DEPTH(32), .LOW_MARK(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model_q[$];
  logic [15:0] sb_q[$];
  bit          exp_valid, exp_over, exp_under;

  // One cycle on instance A; reference model decides acceptance from pre-edge occupancy.
  task automatic beat(input bit we, input logic [31:0] din, input bit re, input bit fl);
    int sz = model_q.size();
    bus_a.wr_en   = we;
    bus_a.data_in = din;
    bus_a.rd_en   = re;
    bus_a.flush   = fl;
    if (fl) begin
      model_q.delete();
      sb_q.delete();
      exp_valid = 0; exp_over = 0; exp_under = 0;
    end else begin
      exp_valid = re && (sz != 0);
      if (re && sz == 0) exp_under = 1;
      if (we && sz > 62) exp_over = 1;
      if (exp_valid) sb_q.push_back(model_q.pop_front());
      if (we && sz <= 62) begin
        model_q.push_back(din[15:0]);
        model_q.push_back(din[31:16]);
      end
    end
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 1'b0;
    bus_a.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_checks++;
    if (bus_a.nwords !== 7'd0 || bus_a.empty !== 1'b1 || bus_a.full !== 1'b0 ||
        bus_a.low !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status_a: nwords=%0d empty=%b full=%b low=%b, want 0 1 0 1",
               bus_a.nwords, bus_a.empty, bus_a.full, bus_a.low);
    end
    n_checks++;
    if (bus_a.data_out !== 16'h0 || bus_a.rd_valid !== 1'b0 || bus_a.overflow !== 1'b0 ||
        bus_a.underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: data_out=%h rd_valid=%b ovf=%b unf=%b, want 0 0 0 0",
               bus_a.data_out, bus_a.rd_valid, bus_a.overflow, bus_a.underflow);
    end
    n_checks++;
    if (bus_b.nwords !== 6'd0 || bus_b.empty !== 1'b1 || bus_b.low !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status_b: nwords=%0d empty=%b low=%b, want 0 1 1",
               bus_b.nwords, bus_b.empty, bus_b.low);
    end
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 32; k++) begin
      beat(1'b1, {16'(2*k+1), 16'(2*k)}, 1'b0, 1'b0);
      n_checks++;
      if (bus_a.nwords !== 7'(2*(k+1)) || bus_a.full !== (k == 31) ||
          bus_a.low !== (2*(k+1) < 16)) begin
        n_fail++;
        $display("FAIL fill_beat%0d: nwords=%0d full=%b low=%b, want %0d %b %b", k,
                 bus_a.nwords, bus_a.full, bus_a.low, 2*(k+1), k == 31, 2*(k+1) < 16);
      end
    end
    beat(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.overflow !== 1'b1 || bus_a.nwords !== 7'd64 || bus_a.full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_overflow: ovf=%b nwords=%0d full=%b, want 1 64 1",
               bus_a.overflow, bus_a.nwords, bus_a.full);
    end
  endtask

  task automatic test_drain_underflow();
    logic [15:0] e;
    for (int i = 0; i < 64; i++) begin
      beat(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (bus_a.rd_valid !== 1'b1 || sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_valid%0d: rd_valid=%b, want 1", i, bus_a.rd_valid);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (bus_a.data_out !== e || e !== 16'(i)) begin
          n_fail++;
          $display("FAIL drain_data%0d: data_out=%0d, want %0d", i, bus_a.data_out, i);
        end
      end
    end
    n_checks++;
    if (bus_a.empty !== 1'b1 || bus_a.low !== 1'b1 || bus_a.nwords !== 7'd0) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b low=%b nwords=%0d, want 1 1 0",
               bus_a.empty, bus_a.low, bus_a.nwords);
    end
    beat(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (bus_a.underflow !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.data_out !== 16'd63) begin
      n_fail++;
      $display("FAIL drain_underflow: unf=%b rd_valid=%b data_out=%0d, want 1 0 63",
               bus_a.underflow, bus_a.rd_valid, bus_a.data_out);
    end
  endtask

  task automatic test_stream_wrap();
    logic [15:0] w = 16'd0;
    logic [15:0] next_out = 16'd0;
    logic [15:0] e;
    int n_read = 0;
    beat(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        beat(1'b1, {w + 16'd1, w}, 1'b1, 1'b0);
        w = w + 16'd2;
      end else begin
        beat(1'b0, 32'h0, 1'b1, 1'b0);
      end
      n_checks++;
      if (bus_a.rd_valid !== exp_valid || bus_a.nwords > 7'd2) begin
        n_fail++;
        $display("FAIL stream_cycle%0d: rd_valid=%b nwords=%0d, want %b <=2", i,
                 bus_a.rd_valid, bus_a.nwords, exp_valid);
      end
      if (exp_valid && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_read++;
        n_checks++;
        if (bus_a.data_out !== e || bus_a.data_out !== next_out) begin
          n_fail++;
          $display("FAIL stream_data%0d: data_out=%0d, want %0d", i, bus_a.data_out, next_out);
        end
        next_out = next_out + 16'd1;
      end
    end
    n_checks++;
    if (n_read < 192) begin
      n_fail++;
      $display("FAIL stream_count: words=%0d, want >=192", n_read);
    end
  endtask

  task automatic test_flush_priority();
    logic [15:0] held;
    for (int i = 0; i < 64 && model_q.size() != 0; i++) beat(1'b0, 32'h0, 1'b1, 1'b0);
    sb_q.delete();
    for (int k = 0; k < 20; k++) beat(1'b1, {16'h2000 + 16'(k), 16'h1000 + 16'(k)}, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.nwords !== 7'd40 || bus_a.underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: nwords=%0d unf=%b, want 40 1", bus_a.nwords, bus_a.underflow);
    end
    held = bus_a.data_out;
    beat(1'b1, 32'hAAAA_5555, 1'b1, 1'b1);
    n_checks++;
    if (bus_a.nwords !== 7'd0 || bus_a.rd_valid !== 1'b0 || bus_a.overflow !== 1'b0 ||
        bus_a.underflow !== 1'b0 || bus_a.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: nwords=%0d rd_valid=%b ovf=%b unf=%b empty=%b, want 0 0 0 0 1",
               bus_a.nwords, bus_a.rd_valid, bus_a.overflow, bus_a.underflow, bus_a.empty);
    end
    n_checks++;
    if (bus_a.data_out !== held) begin
      n_fail++;
      $display("FAIL flush_hold: data_out=%h, want %h", bus_a.data_out, held);
    end
    beat(1'b1, 32'h0002_0001, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.nwords !== 7'd2) begin
      n_fail++;
      $display("FAIL flush_nostore: nwords=%0d, want 2", bus_a.nwords);
    end
    beat(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (sb_q.size() == 0 || bus_a.data_out !== sb_q.pop_front() || bus_a.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_first_word: data_out=%h rd_valid=%b, want 0001 1",
               bus_a.data_out, bus_a.rd_valid);
    end
  endtask

  task automatic test_same_cycle_empty();
    beat(1'b0, 32'h0, 1'b0, 1'b1);
    beat(1'b1, 32'h0B0B_0A0A, 1'b1, 1'b0);
    n_checks++;
    if (bus_a.underflow !== 1'b1 || bus_a.rd_valid !== 1'b0 || bus_a.nwords !== 7'd2) begin
      n_fail++;
      $display("FAIL same_cycle: unf=%b rd_valid=%b nwords=%0d, want 1 0 2",
               bus_a.underflow, bus_a.rd_valid, bus_a.nwords);
    end
    for (int i = 0; i < 2; i++) begin
      beat(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (sb_q.size() == 0 || bus_a.rd_valid !== 1'b1 || bus_a.data_out !== sb_q.pop_front()) begin
        n_fail++;
        $display("FAIL same_cycle_read%0d: data_out=%h rd_valid=%b, want %h 1", i,
                 bus_a.data_out, bus_a.rd_valid, (i == 0) ? 16'h0A0A : 16'h0B0B);
      end
    end
  endtask

  task automatic test_reset_midway();
    for (int k = 0; k < 10; k++) beat(1'b1, {16'h3000 + 16'(k), 16'h4000 + 16'(k)}, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.nwords !== 7'd20) begin
      n_fail++;
      $display("FAIL midreset_setup: nwords=%0d, want 20", bus_a.nwords);
    end
    bus_a.wr_en = 1'b1; bus_a.rd_en = 1'b1; bus_a.data_in = 32'h5555_6666; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    model_q.delete(); sb_q.delete();
    exp_valid = 0; exp_over = 0; exp_under = 0;
    n_checks++;
    if (bus_a.nwords !== 7'd0 || bus_a.rd_valid !== 1'b0 || bus_a.data_out !== 16'h0 ||
        bus_a.overflow !== 1'b0 || bus_a.underflow !== 1'b0 || bus_a.full !== 1'b0 ||
        bus_a.empty !== 1'b1 || bus_a.low !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_values: nwords=%0d rv=%b dout=%h ovf=%b unf=%b f=%b e=%b l=%b",
               bus_a.nwords, bus_a.rd_valid, bus_a.data_out, bus_a.overflow,
               bus_a.underflow, bus_a.full, bus_a.empty, bus_a.low);
    end
    beat(1'b1, 32'h7777_8888, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.nwords !== 7'd2) begin
      n_fail++;
      $display("FAIL midreset_first_write: nwords=%0d, want 2", bus_a.nwords);
    end
  endtask

  task automatic test_alt_geometry();
    logic [7:0] sb_b[$];
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      bus_b.wr_en   = 1'b1;
      bus_b.data_in = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      for (int l = 0; l < 4; l++) sb_b.push_back(8'(4*k+l));
      @(posedge clk); #1;
      n_checks++;
      if (bus_b.nwords !== 6'(4*(k+1)) || bus_b.full !== (k == 7)) begin
        n_fail++;
        $display("FAIL alt_fill%0d: nwords=%0d full=%b, want %0d %b", k,
                 bus_b.nwords, bus_b.full, 4*(k+1), k == 7);
      end
    end
    bus_b.data_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_b.wr_en = 1'b0;
    n_checks++;
    if (bus_b.overflow !== 1'b1 || bus_b.nwords !== 6'd32) begin
      n_fail++;
      $display("FAIL alt_overflow: ovf=%b nwords=%0d, want 1 32", bus_b.overflow, bus_b.nwords);
    end
    bus_b.rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      e = sb_b.pop_front();
      n_checks++;
      if (bus_b.rd_valid !== 1'b1 || bus_b.data_out !== e) begin
        n_fail++;
        $display("FAIL alt_read%0d: data_out=%0d rd_valid=%b, want %0d 1", i,
                 bus_b.data_out, bus_b.rd_valid, e);
      end
    end
    bus_b.rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.flush = 1'b0; bus_a.data_in = '0;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.flush = 1'b0; bus_b.data_in = '0;
    exp_valid = 0; exp_over = 0; exp_under = 0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_stream_wrap();
    test_flush_priority();
    test_same_cycle_empty();
    test_reset_midway();
    test_alt_geometry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
